// File: rtl/bp_pkg.sv
// Branch predictor shared types: 2-bit counter encodings, FSM state, saturating helpers.
// Latency: n/a (types and pure functions). Backpressure: n/a.
// Flow control: none; imported by branch_predictor and branch_btb.
package bp_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'b00;
    localparam ctr_t CTR_WNT = 2'b01;
    localparam ctr_t CTR_WT  = 2'b10;
    localparam ctr_t CTR_ST  = 2'b11;

    typedef enum logic {
        BP_INIT,
        BP_RUN
    } bp_state_t;

    function automatic ctr_t sat_inc(input ctr_t c);
        return (c == CTR_ST) ? CTR_ST : ctr_t'(c + 2'd1);
    endfunction

    function automatic ctr_t sat_dec(input ctr_t c);
        return (c == CTR_SNT) ? CTR_SNT : ctr_t'(c - 2'd1);
    endfunction

endpackage

// File: rtl/branch_btb.sv
// Direct-mapped branch target buffer: valid/tag/target per entry.
// Latency: combinational read, write lands at the next rising edge.
// Backpressure: none; a write is accepted every cycle wr_en is high.
module branch_btb #(
    parameter int ENTRIES = 16,
    parameter int IW      = 4,
    parameter int TAG_W   = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IW-1:0]    rd_idx,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             rd_hit,
    output logic [31:0]      rd_target,
    input  logic             wr_en,
    input  logic [IW-1:0]    wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [31:0]      wr_target
);

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag_mem [ENTRIES];
    logic [31:0]        tgt_mem [ENTRIES];

    // Only the valid bits are reset; tag/target contents are don't-care until written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx] <= wr_tag;
            tgt_mem[wr_idx] <= wr_target;
        end
    end

    assign rd_hit    = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    assign rd_target = rd_hit ? tgt_mem[rd_idx] : 32'd0;

endmodule

// File: rtl/branch_predictor.sv
// 2-bit BHT + direct-mapped BTB direction/target predictor; BP_GSHARE_EN selects gshare indexing.
// Latency: zero-cycle IF lookup and EX resolution; tables update at the next rising edge.
// Backpressure: ready stays low for BHT_ENTRIES cycles after reset while the BHT is swept; EX is ignored then.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int BHT_ENTRIES = 64,
    parameter int BTB_ENTRIES = 16,
    parameter int GHR_BITS    = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                ready,
    input  logic [31:0]         if_pc,
    output logic                pred_taken,
    output logic [31:0]         pred_target,
    output logic [GHR_BITS-1:0] if_ghr,
    input  logic                ex_valid,
    input  logic [31:0]         ex_pc,
    input  logic                ex_taken,
    input  logic [31:0]         ex_target,
    input  logic                ex_pred_taken,
    input  logic [31:0]         ex_pred_target,
    input  logic [GHR_BITS-1:0] ex_ghr,
    output logic                mispredict,
    output logic [31:0]         redirect_pc
);

    localparam int BHT_IW = $clog2(BHT_ENTRIES);
    localparam int BTB_IW = $clog2(BTB_ENTRIES);
    localparam int TAG_W  = 32 - BTB_IW - 2;

    bp_state_t         state, state_nxt;
    logic [BHT_IW-1:0] sweep_idx;
    ctr_t              bht [BHT_ENTRIES];

    logic              upd_en;
    logic [BHT_IW-1:0] rd_idx, upd_idx;
    logic              bht_we;
    logic [BHT_IW-1:0] bht_widx;
    ctr_t              bht_wdat;
    logic              btb_hit;
    logic [31:0]       btb_target;

    assign upd_en = ex_valid & ready;

`ifdef BP_GSHARE_EN
    logic [GHR_BITS-1:0] ghr;

    // History advances only on resolved branches, so it never needs repair on a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr <= '0;
        end else if (upd_en) begin
            ghr <= {ghr[GHR_BITS-2:0], ex_taken};
        end
    end

    assign rd_idx  = if_pc[BHT_IW+1:2] ^ BHT_IW'(ghr);
    assign upd_idx = ex_pc[BHT_IW+1:2] ^ BHT_IW'(ex_ghr);
    assign if_ghr  = ghr;
`else
    logic unused_ex_ghr;
    assign unused_ex_ghr = ^ex_ghr;
    assign rd_idx        = if_pc[BHT_IW+1:2];
    assign upd_idx       = ex_pc[BHT_IW+1:2];
    assign if_ghr        = '0;
`endif

    logic unused_pc_lsb;
    assign unused_pc_lsb = ^if_pc[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BP_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            BP_INIT: if (sweep_idx == BHT_IW'(BHT_ENTRIES - 1)) state_nxt = BP_RUN;
            BP_RUN:  state_nxt = BP_RUN;
            default: state_nxt = BP_INIT;
        endcase
    end

    always_comb begin
        ready    = 1'b0;
        bht_we   = 1'b0;
        bht_widx = sweep_idx;
        bht_wdat = CTR_WNT;
        case (state)
            BP_INIT: bht_we = 1'b1;
            BP_RUN: begin
                ready    = 1'b1;
                bht_we   = ex_valid;
                bht_widx = upd_idx;
                bht_wdat = ex_taken ? sat_inc(bht[upd_idx]) : sat_dec(bht[upd_idx]);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sweep_idx <= '0;
        end else if (state == BP_INIT) begin
            sweep_idx <= sweep_idx + BHT_IW'(1);
        end
    end

    // Counter array needs no reset: the INIT sweep writes every entry before ready rises.
    always_ff @(posedge clk) begin
        if (bht_we) begin
            bht[bht_widx] <= bht_wdat;
        end
    end

    branch_btb #(
        .ENTRIES (BTB_ENTRIES),
        .IW      (BTB_IW),
        .TAG_W   (TAG_W)
    ) u_btb (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (if_pc[BTB_IW+1:2]),
        .rd_tag    (if_pc[31:BTB_IW+2]),
        .rd_hit    (btb_hit),
        .rd_target (btb_target),
        .wr_en     (upd_en & ex_taken),
        .wr_idx    (ex_pc[BTB_IW+1:2]),
        .wr_tag    (ex_pc[31:BTB_IW+2]),
        .wr_target (ex_target)
    );

    assign pred_taken  = ready & btb_hit & bht[rd_idx][1];
    assign pred_target = btb_target;

    assign mispredict  = upd_en & ((ex_taken != ex_pred_taken) |
                                   (ex_taken & (ex_pred_target != ex_target)));
    assign redirect_pc = ex_taken ? ex_target : ex_pc + 32'd4;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (default bimodal build; GHR pattern check under BP_GSHARE_EN).
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ready;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [5:0]  if_ghr;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic [5:0]  ex_ghr;
    logic        mispredict;
    logic [31:0] redirect_pc;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ready          (ready),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .if_ghr         (if_ghr),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .ex_ghr         (ex_ghr),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic lookup(input logic [31:0] pc, input logic exp_pt, input logic [31:0] exp_tgt,
                          input string tag);
        if_pc = pc;
        #1;
        check({tag, "_pt"}, pred_taken, exp_pt);
        check({tag, "_tgt"}, pred_target, exp_tgt);
    endtask

    task automatic resolve(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                           input logic pt, input logic [31:0] ptgt,
                           input logic exp_mis, input logic [31:0] exp_redir, input string tag);
        ex_valid       = 1'b1;
        ex_pc          = pc;
        ex_taken       = t;
        ex_target      = tgt;
        ex_pred_taken  = pt;
        ex_pred_target = ptgt;
        #1;
        check({tag, "_mis"}, mispredict, exp_mis);
        check({tag, "_redir"}, redirect_pc, exp_redir);
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
    endtask

    task automatic sweep(input string tag);
        for (int i = 1; i <= 64; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s_rdy%0d", tag, i), ready, (i == 64));
            if (i < 64) check($sformatf("%s_pt%0d", tag, i), pred_taken, 1'b0);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        if_pc          = 32'h100;
        ex_valid       = 1'b1;
        ex_pc          = 32'h200;
        ex_taken       = 1'b1;
        ex_target      = 32'h180;
        ex_pred_taken  = 1'b0;
        ex_pred_target = 32'h0;
        ex_ghr         = 6'd0;

        // Reset state, with an EX request that must be ignored.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", ready, 1'b0);
        check("rst_pt", pred_taken, 1'b0);
        check("rst_mis", mispredict, 1'b0);
        check("rst_ghr", if_ghr, 6'd0);

        @(negedge clk);
        rst_n = 1'b1;
        sweep("t1");
        ex_valid = 1'b0;
        lookup(32'h200, 1'b0, 32'h0, "t1_ignored");

        // Train 0x200 -> 0x180: WNT->WT->ST.
        resolve(32'h200, 1'b1, 32'h180, 1'b0, 32'h0,   1'b1, 32'h180, "t2_tk1");
        lookup(32'h200, 1'b1, 32'h180, "t2_wt");
        resolve(32'h200, 1'b1, 32'h180, 1'b1, 32'h180, 1'b0, 32'h180, "t2_tk2");
        resolve(32'h200, 1'b1, 32'h180, 1'b1, 32'h180, 1'b0, 32'h180, "t2_tk3");
        lookup(32'h200, 1'b1, 32'h180, "t2_st");

        // Not-taken walk down from ST and saturation at SNT.
        resolve(32'h200, 1'b0, 32'h180, 1'b1, 32'h180, 1'b1, 32'h204, "t3_nt1");
        lookup(32'h200, 1'b1, 32'h180, "t3_wt");
        resolve(32'h200, 1'b0, 32'h180, 1'b1, 32'h180, 1'b1, 32'h204, "t3_nt2");
        lookup(32'h200, 1'b0, 32'h180, "t3_wnt");
        resolve(32'h200, 1'b0, 32'h180, 1'b0, 32'h180, 1'b0, 32'h204, "t3_nt3");
        resolve(32'h200, 1'b0, 32'h180, 1'b0, 32'h180, 1'b0, 32'h204, "t3_nt4");
        lookup(32'h200, 1'b0, 32'h180, "t3_snt");
        resolve(32'h200, 1'b0, 32'h180, 1'b0, 32'h180, 1'b0, 32'h204, "t3_nt5");
        lookup(32'h200, 1'b0, 32'h180, "t3_snt_hold");
        resolve(32'h200, 1'b1, 32'h180, 1'b0, 32'h180, 1'b1, 32'h180, "t3_tk_a");
        lookup(32'h200, 1'b0, 32'h180, "t3_from_snt");
        resolve(32'h200, 1'b1, 32'h180, 1'b0, 32'h180, 1'b1, 32'h180, "t3_tk_b");
        lookup(32'h200, 1'b1, 32'h180, "t3_wt_again");

        // Aliasing: same BTB index, different tag.
        lookup(32'h240, 1'b0, 32'h0, "t4_alias");

        // Target mismatch; same-cycle lookup sees the pre-update target.
        if_pc          = 32'h200;
        ex_valid       = 1'b1;
        ex_pc          = 32'h200;
        ex_taken       = 1'b1;
        ex_target      = 32'h1C0;
        ex_pred_taken  = 1'b1;
        ex_pred_target = 32'h180;
        #1;
        check("t5_mis", mispredict, 1'b1);
        check("t5_redir", redirect_pc, 32'h1C0);
        check("t5_pre_tgt", pred_target, 32'h180);
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        lookup(32'h200, 1'b1, 32'h1C0, "t5_post");

        // ex_valid low suppresses mispredict; not-taken redirect wraps at 2^32.
        ex_taken      = 1'b1;
        ex_pred_taken = 1'b0;
        #1;
        check("noval_mis", mispredict, 1'b0);
        resolve(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, "wrap");

        // Asynchronous reset in RUN, then again mid-sweep.
        if_pc = 32'h200;
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_run_ready", ready, 1'b0);
        check("t6_run_pt", pred_taken, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("t6_mid_ready", ready, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_mid_rst_ready", ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        sweep("t6");
        lookup(32'h200, 1'b0, 32'h0, "t6_btb_clr");
        resolve(32'h200, 1'b1, 32'h180, 1'b0, 32'h0,   1'b1, 32'h180, "t6_tk");
        lookup(32'h200, 1'b1, 32'h180, "t6_wt");
        resolve(32'h200, 1'b0, 32'h180, 1'b1, 32'h180, 1'b1, 32'h204, "t6_nt");
        lookup(32'h200, 1'b0, 32'h180, "t6_reinit");

`ifdef BP_GSHARE_EN
        rst_n = 1'b0;
        #1;
        check("gs_rst_ghr", if_ghr, 6'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (64) @(posedge clk);
        #1;
        ex_ghr = if_ghr;
        resolve(32'h300, 1'b1, 32'h380, 1'b0, 32'h0, 1'b1, 32'h380, "gs_t1");
        ex_ghr = if_ghr;
        resolve(32'h300, 1'b0, 32'h380, 1'b0, 32'h0, 1'b0, 32'h304, "gs_n");
        ex_ghr = if_ghr;
        resolve(32'h300, 1'b1, 32'h380, 1'b0, 32'h0, 1'b1, 32'h380, "gs_t2");
        check("gs_ghr", if_ghr, 6'b000101);
`else
        check("ghr_tied", if_ghr, 6'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
